// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate controller: one bit position per clock, start/done handshake.
// The result is registered and only updates when an operation completes.
module shift_sequencer #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   operand,
    input  logic [SHAMT_W-1:0] amount,
    output logic               busy,
    output logic               done,
    output logic               illegal,
    output logic [WIDTH-1:0]   result
);

    // state | meaning
    // IDLE  | waiting for start
    // SHIFT | moving acc one bit per clock, count > 0
    // DONE  | one-cycle completion, may re-accept start
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [2:0] OP_SHR  = 3'b000;
    localparam logic [2:0] OP_SHRA = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_ROR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   acc, acc_shift;
    logic [SHAMT_W-1:0] count;
    logic [2:0]         op_q;
    logic               accept, op_bad, short_req, last_shift;

    always_comb begin
        op_bad     = (op > OP_ROL);
        accept     = start && (state != SHIFT);
        short_req  = (amount == '0) || op_bad;
        last_shift = (state == SHIFT) && (count == SHAMT_W'(1));

        acc_shift = acc;
        case (op_q)
            OP_SHR:  acc_shift = {1'b0, acc[WIDTH-1:1]};
            OP_SHRA: acc_shift = {acc[WIDTH-1], acc[WIDTH-1:1]};
            OP_SHL:  acc_shift = {acc[WIDTH-2:0], 1'b0};
            OP_ROR:  acc_shift = {acc[0], acc[WIDTH-1:1]};
            OP_ROL:  acc_shift = {acc[WIDTH-2:0], acc[WIDTH-1]};
            default: acc_shift = acc;
        endcase

        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (accept) state_nxt = short_req ? DONE : SHIFT;
                else        state_nxt = IDLE;
            end
            SHIFT: if (last_shift) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // busy drops on the final shift edge so a one-bit request never shows busy
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            acc     <= '0;
            count   <= '0;
            op_q    <= '0;
            result  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            illegal <= 1'b0;
        end else begin
            if (accept) begin
                acc   <= operand;
                count <= amount;
                op_q  <= op;
            end else if (state == SHIFT) begin
                acc   <= acc_shift;
                count <= count - SHAMT_W'(1);
            end

            if (accept && short_req) result <= operand;
            else if (last_shift)     result <= acc_shift;

            busy    <= (state == SHIFT) && !last_shift;
            done    <= (state_nxt == DONE);
            illegal <= accept && op_bad;
        end
    end

endmodule
